fifo_frame_reader: RTL and testbench
====================================

Name: fifo_frame_reader

Overview:
- Read-side drain controller for the async FIFO in the MAC datapath, in the rclk domain.
- Pops bytes from the FIFO read port and parses a 2-byte big-endian length header in front of each frame.
- Emits the payload as a valid/ready byte stream with tlast on the final byte, for the TX MAC framer.
- Oversize and zero-length frames are flagged; oversize payloads are consumed and discarded so the FIFO stays frame-aligned.

Parameters:
WIDTH, 8, data byte width; header bytes are WIDTH wide.
LEN_W, 16, length field width (2*WIDTH).
MAX_LEN, 1518, largest payload length forwarded; larger lengths are dropped.

Ports:
rclk  input  1  read-domain clock
arst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty flag, rclk domain
fifo_data  input  WIDTH  FIFO read data, valid one cycle after an accepted fifo_rd_en
fifo_rd_en  output  1  FIFO pop request
m_tdata  output  WIDTH  payload byte
m_tvalid  output  1  m_tdata valid
m_tready  input  1  downstream accept
m_tlast  output  1  last payload byte of frame
frame_done  output  1  one-cycle pulse when the tlast byte handshakes
len_err  output  1  one-cycle pulse on a zero or oversize length header

Behaviour:
- Reset: arst_n low asynchronously clears all state.
  - State goes to HDR_HI.
  - fifo_rd_en, m_tvalid, m_tlast, frame_done and len_err go to 0.
  - m_tdata goes to 0; the in-flight flag, buffer and counters clear.
  - Release is consumed on rclk; no activity in the first cycle after deassertion.
- FIFO read timing:
  - fifo_rd_en asserts only when fifo_empty=0.
  - Every asserted cycle is one pop; the byte arrives on fifo_data the next cycle. An in-flight flag tracks it.
- Credit rule:
  - occ is the output buffer occupancy (0..2); inflight is 0 or 1.
  - Only payload bytes in PAYLOAD consume a buffer slot.
  - fifo_rd_en = !fifo_empty && (occ + inflight < 2 || (occ + inflight == 2 && m_tvalid && m_tready)).
  - This sustains 1 byte/cycle with m_tready held high.
  - The buffer never overflows, including when the header byte that opens a frame is followed directly by payload.
- Parser FSM, advancing on each arriving byte (cycle after a pop):
  - HDR_HI: latch len[15:8] -> HDR_LO.
  - HDR_LO: form len = {hi, byte}.
    - len==0: pulse len_err -> HDR_HI.
    - len>MAX_LEN: pulse len_err, rem=len -> DROP.
    - Else rem=len -> PAYLOAD.
  - PAYLOAD: push {byte, last=(rem==1)} into the buffer; rem--. rem reaching 0 -> HDR_HI.
  - DROP: discard byte; rem--. rem reaching 0 -> HDR_HI. No output and no frame_done.
- Output buffer:
  - 2-entry FIFO; head drives m_tdata/m_tlast; m_tvalid = (occ != 0).
  - m_tdata/m_tlast stay stable while m_tvalid && !m_tready.
  - A push and a pop in the same cycle are both honoured and occ is unchanged.
- frame_done pulses the cycle after the handshake of the m_tlast=1 byte.
- Back-to-back frames: the next header is popped without a gap cycle; the parser switches on the byte following tlast.
- rem is LEN_W bits and never underflows; it is only decremented in PAYLOAD/DROP while nonzero.
- fifo_empty rising while a byte is in flight: that byte is still captured; no further pops.
- Reset mid-frame discards the partial frame. The system resets the FIFO with the same arst_n, so no realignment is needed.

Decomposition:
- Package frame_rd_pkg holds:
  - typedef enum state_t {HDR_HI, HDR_LO, PAYLOAD, DROP};
  - LEN_W localparam;
  - packed struct buf_entry_t {data, last}.
- One sub-module, stream_skid_buf: 2-entry valid/ready buffer with push/pop and occ output.
- Credit logic and FSM stay in fifo_frame_reader.

Test Plan:
- FIFO holds 00 03 AA BB CC, m_tready=1 -> m_tdata AA,BB,CC on 3 consecutive cycles, m_tlast only on CC, one frame_done pulse.
- Same frame, m_tready toggles 1,0,0,1,1 -> no byte lost or duplicated; data stable while stalled; fifo_rd_en never pops with occ+inflight=2 and no handshake.
- FIFO holds 00 00 then 00 01 5A -> one len_err pulse; output is a single byte 5A with m_tlast=1.
- With MAX_LEN=4, FIFO holds 00 06 + six bytes, then 00 02 11 22 -> one len_err; six bytes dropped, m_tvalid stays low; then 11, 22 with tlast on 22.
- fifo_empty toggles randomly during a 100-byte frame with m_tready=1 -> exactly 100 bytes out in order; tlast on byte 100; fifo_rd_en never high while fifo_empty=1.
- arst_n pulsed low mid-payload -> all outputs 0 immediately; after release with a refilled FIFO 00 02 01 02, clean frame 01, 02.

Source files
------------

// File: rtl/frame_rd_pkg.sv
// frame_rd_pkg: shared parser states, widths and buffer entry type for the FIFO frame reader
package frame_rd_pkg;
  localparam int DATA_W = 8;
  localparam int LEN_W = 2 * DATA_W;
  typedef enum logic [1:0] {HDR_HI, HDR_LO, PAYLOAD, DROP} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic last;
  } buf_entry_t;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry valid/ready output buffer; simultaneous push and pop keep occ unchanged
module stream_skid_buf
  import frame_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  buf_entry_t din,
  input  logic       pop,
  output buf_entry_t head,
  output logic [1:0] occ
);
  buf_entry_t mem [2];
  logic wp, rp;
  assign head = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      occ <= occ + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains length-prefixed frames from the async FIFO read port into a
// valid/ready byte stream, dropping zero-length and oversize frames while staying frame-aligned
module fifo_frame_reader
  import frame_rd_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int LEN_W = frame_rd_pkg::LEN_W,
  parameter int MAX_LEN = 1518
) (
  input  logic             rclk,
  input  logic             arst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             frame_done,
  output logic             len_err
);
  state_t state;
  logic run, inflight, hs, push, bad;
  logic [WIDTH-1:0] hi;
  logic [LEN_W-1:0] rem, len;
  logic [1:0] occ, credit;
  buf_entry_t head;
  assign hs = m_tvalid && m_tready;
  // a byte in flight reserves a buffer slot even if it turns out to be a header byte
  assign credit = occ + 2'(inflight);
  assign fifo_rd_en = run && !fifo_empty && (credit < 2'd2 || (credit == 2'd2 && hs));
  assign len = {hi, fifo_data};
  assign bad = len == '0 || len > LEN_W'(MAX_LEN);
  assign push = inflight && state == PAYLOAD;
  assign m_tvalid = occ != 2'd0;
  assign m_tdata = head.data;
  assign m_tlast = head.last;
  always_ff @(posedge rclk or negedge arst_n)
    if (!arst_n) begin
      state <= HDR_HI;
      run <= 1'b0;
      inflight <= 1'b0;
      hi <= '0;
      rem <= '0;
      frame_done <= 1'b0;
      len_err <= 1'b0;
    end else begin
      run <= 1'b1;
      inflight <= fifo_rd_en;
      frame_done <= hs && m_tlast;
      len_err <= inflight && state == HDR_LO && bad;
      if (inflight)
        case (state)
          HDR_HI: begin
            hi <= fifo_data;
            state <= HDR_LO;
          end
          HDR_LO: begin
            rem <= len;
            state <= bad ? (len == '0 ? HDR_HI : DROP) : PAYLOAD;
          end
          default: begin
            if (rem != '0) rem <= rem - 1'b1;
            if (rem <= LEN_W'(1)) state <= HDR_HI;
          end
        endcase
    end
  stream_skid_buf u_buf (
    .clk   (rclk),
    .rst_n (arst_n),
    .push  (push),
    .din   ('{data: fifo_data, last: rem == LEN_W'(1)}),
    .pop   (hs),
    .head  (head),
    .occ   (occ)
  );
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: FIFO and sink model around the frame reader, checking the byte stream
// against a frame-level model built from each header as frames are queued
module tb_fifo_frame_reader;
  localparam int MAX = 120;
  logic rclk = 1'b0;
  logic arst_n = 1'b1;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic fifo_rd_en, m_tvalid, m_tlast, frame_done, len_err;
  logic m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic [7:0] fq[$], pl[$];
  logic [8:0] exp_q[$], out_log[$], want[$];
  int out_cyc[$];
  int nchk = 0, nfail = 0, cyc = 0;
  int exp_err = 0, exp_done = 0, err_seen = 0, done_seen = 0, saved_done;
  int rmode = 0;
  logic emode = 1'b0;
  logic [4:0] pat = 5'b11001;
  logic prev_hs_last = 1'b0, prev_stall = 1'b0, prev_lst = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fifo_frame_reader #(.MAX_LEN(MAX)) dut (
    .rclk       (rclk),
    .arst_n     (arst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .frame_done (frame_done),
    .len_err    (len_err)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // read-port model: a pop returns the head byte on the following cycle
  always @(posedge rclk)
    if (fifo_rd_en) begin
      chk("pop_nonempty", 32'(fq.size() != 0), 1);
      if (fq.size() != 0) fifo_data <= fq.pop_front();
    end

  always @(posedge rclk) begin
    #1;
    cyc++;
    m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? pat[cyc % 5] : 1'($urandom_range(0, 1));
    fifo_empty = (emode && $urandom_range(0, 2) == 0) || fq.size() == 0;
  end

  always @(negedge rclk) begin
    logic [8:0] e;
    logic hs;
    if (!arst_n) begin
      prev_hs_last = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
      chk("frame_done", 32'(frame_done), 32'(prev_hs_last));
      if (prev_stall) begin
        chk("stall_valid", 32'(m_tvalid), 1);
        chk("stall_data", 32'(m_tdata), 32'(prev_data));
        chk("stall_last", 32'(m_tlast), 32'(prev_lst));
      end
      if (len_err) err_seen++;
      if (frame_done) done_seen++;
      hs = m_tvalid && m_tready;
      if (hs) begin
        chk("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", 32'(m_tdata), 32'(e[7:0]));
          chk("tlast", 32'(m_tlast), 32'(e[8]));
        end
        out_log.push_back({m_tlast, m_tdata});
        out_cyc.push_back(cyc);
      end
      prev_hs_last = hs && m_tlast;
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_lst = m_tlast;
    end
  end

  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic rand_pl(input int len);
    pl.delete();
    repeat (len) pl.push_back(8'($urandom));
  endtask

  // queues header+payload into the FIFO and records what the stream must show for it
  task automatic add_frame(input int len);
    fq.push_back(8'(len >> 8));
    fq.push_back(8'(len));
    for (int i = 0; i < len; i++) fq.push_back(pl[i]);
    if (len == 0 || len > MAX) exp_err++;
    else begin
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pl[i]});
      exp_done++;
    end
  endtask

  task automatic drain(input string n);
    int k = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && k < 20000) begin
      step();
      k++;
    end
    chk({n, "_drain_in_budget"}, 32'(k < 20000), 1);
    repeat (4) step();
    chk({n, "_len_err_count"}, 32'(err_seen), 32'(exp_err));
    chk({n, "_frame_done_count"}, 32'(done_seen), 32'(exp_done));
  endtask

  task automatic chk_log(input string n);
    chk({n, "_count"}, 32'(out_log.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < out_log.size(); i++)
      chk({n, "_byte"}, 32'(out_log[i]), 32'(want[i]));
  endtask

  task automatic clr_log();
    out_log.delete();
    out_cyc.delete();
  endtask

  initial begin
    #2 arst_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_len_err", 32'(len_err), 0);
    repeat (3) @(posedge rclk);
    #3 arst_n = 1'b1;
    step();

    clr_log();
    pl = '{8'hAA, 8'hBB, 8'hCC};
    add_frame(3);
    drain("t1");
    want = '{9'h0AA, 9'h0BB, 9'h1CC};
    chk_log("t1_out");
    if (out_cyc.size() == 3) chk("t1_back_to_back", 32'(out_cyc[2] - out_cyc[0]), 2);
    chk("t1_one_done", 32'(done_seen), 1);

    rmode = 1;
    clr_log();
    add_frame(3);
    drain("t2");
    chk_log("t2_out");
    rmode = 0;

    clr_log();
    pl.delete();
    add_frame(0);
    pl = '{8'h5A};
    add_frame(1);
    drain("t3");
    want = '{9'h15A};
    chk_log("t3_out");
    chk("t3_one_err", 32'(err_seen), 1);

    clr_log();
    rand_pl(MAX + 1);
    add_frame(MAX + 1);
    pl = '{8'h11, 8'h22};
    add_frame(2);
    drain("t4");
    want = '{9'h011, 9'h122};
    chk_log("t4_out");
    chk("t4_errs", 32'(err_seen), 2);

    clr_log();
    rand_pl(MAX);
    add_frame(MAX);
    drain("t_max");
    chk("t_max_count", 32'(out_log.size()), MAX);

    emode = 1'b1;
    clr_log();
    rand_pl(100);
    add_frame(100);
    drain("t5");
    chk("t5_count", 32'(out_log.size()), 100);

    rmode = 2;
    for (int f = 0; f < 25; f++) begin
      int len;
      int sel;
      sel = $urandom_range(0, 9);
      len = sel == 0 ? 0 : sel == 1 ? MAX + 1 + $urandom_range(0, 6) : $urandom_range(1, 60);
      rand_pl(len);
      add_frame(len);
    end
    drain("t_rand");

    rmode = 0;
    emode = 1'b0;
    rand_pl(64);
    saved_done = exp_done;
    add_frame(64);
    repeat (20) step();
    #1 arst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
    chk("mid_rst_tvalid", 32'(m_tvalid), 0);
    chk("mid_rst_tlast", 32'(m_tlast), 0);
    chk("mid_rst_tdata", 32'(m_tdata), 0);
    chk("mid_rst_frame_done", 32'(frame_done), 0);
    chk("mid_rst_len_err", 32'(len_err), 0);
    fq.delete();
    exp_q.delete();
    exp_done = saved_done;
    clr_log();
    pl = '{8'h01, 8'h02};
    add_frame(2);
    repeat (2) step();
    @(posedge rclk);
    #3 arst_n = 1'b1;
    #1;
    chk("release_empty_flag", 32'(fifo_empty), 0);
    chk("release_quiet", 32'(fifo_rd_en), 0);
    drain("t_rst");
    want = '{9'h001, 9'h102};
    chk_log("t_rst_out");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
